// File: rtl/cma_eq_ctrl.sv
// Sequencing controller for the CMA blind equalizer: flush, windowed training, lock tracking and timeout.
// Optional build macro CMA_EQ_CTRL_IRQ_EN adds an irq pulse on lock, unlock and fail events.
module cma_eq_ctrl #(
    parameter int ERR_W        = 32,
    parameter int WIN_LOG2     = 6,
    parameter int FLUSH_LEN    = 16,
    parameter int LOCK_WINS    = 4,
    parameter int TIMEOUT_WINS = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             eq_out_valid,
    input  logic [ERR_W-1:0] eq_error_mag,
    input  logic [ERR_W-1:0] lock_thresh,
    input  logic [ERR_W-1:0] unlock_thresh,
    output logic             eq_enable,
    output logic             out_gate,
    output logic             locked,
    output logic             fail,
    output logic [2:0]       state,
    output logic [ERR_W-1:0] win_err_avg,
    output logic [15:0]      win_count
`ifdef CMA_EQ_CTRL_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int ACC_W  = ERR_W + WIN_LOG2;
    localparam int FL_W   = $clog2(FLUSH_LEN + 1);
    localparam int CNT_W  = (WIN_LOG2 > FL_W) ? WIN_LOG2 : FL_W;
    localparam int GOOD_W = $clog2(LOCK_WINS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        TRAIN  = 3'd2,
        LOCKED = 3'd3,
        FAIL   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [15:0]       win_cnt_d, win_cnt_inc;
    logic [ERR_W-1:0]  avg_d, avg_new;
    logic              win_done, is_good;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        acc_sum     = acc_q + ACC_W'(eq_error_mag);
        avg_new     = ERR_W'(acc_sum >> WIN_LOG2);
        win_cnt_inc = sat_inc16(win_count);
        win_done    = eq_out_valid && (cnt_q == CNT_W'((1 << WIN_LOG2) - 1));
        is_good     = (avg_new < lock_thresh);

        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        good_d    = good_q;
        win_cnt_d = win_count;
        avg_d     = win_err_avg;

        // stop overrides start and any window decision in the same cycle
        if (stop) begin
            state_d   = IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            good_d    = '0;
            win_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE, FAIL: begin
                    if (start) begin
                        state_d = FLUSH;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                FLUSH: begin
                    if (eq_out_valid) begin
                        if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
                            state_d   = TRAIN;
                            acc_d     = '0;
                            cnt_d     = '0;
                            good_d    = '0;
                            win_cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                TRAIN, LOCKED: begin
                    if (win_done) begin
                        acc_d     = '0;
                        cnt_d     = '0;
                        avg_d     = avg_new;
                        win_cnt_d = win_cnt_inc;
                        if (state_q == TRAIN) begin
                            good_d = is_good ? good_q + GOOD_W'(1) : '0;
                            // lock wins over timeout on the same window
                            if (is_good && good_q == GOOD_W'(LOCK_WINS - 1))
                                state_d = LOCKED;
                            else if (win_cnt_inc >= 16'(TIMEOUT_WINS))
                                state_d = FAIL;
                        end else if (avg_new > unlock_thresh) begin
                            state_d   = TRAIN;
                            good_d    = '0;
                            win_cnt_d = '0;
                        end
                    end else if (eq_out_valid) begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            good_q      <= '0;
            win_count   <= '0;
            win_err_avg <= '0;
            eq_enable   <= 1'b0;
            out_gate    <= 1'b0;
            locked      <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            good_q      <= good_d;
            win_count   <= win_cnt_d;
            win_err_avg <= avg_d;
            eq_enable   <= (state_d == FLUSH) || (state_d == TRAIN) || (state_d == LOCKED);
            out_gate    <= (state_d == LOCKED);
            locked      <= (state_d == LOCKED);
            fail        <= (state_d == FAIL);
        end
    end

`ifdef CMA_EQ_CTRL_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq <= 1'b0;
        else
            irq <= !stop && (state_d != state_q) &&
                   ((state_d == LOCKED) || (state_d == FAIL) || (state_q == LOCKED));
    end
`endif

    assign state = state_q;

endmodule
